// File: rtl/vreg_burst_reader.sv
// Burst reader: streams cmd_len register-file entries from cmd_addr through a 2-entry skid FIFO.
// Optional macro VREG_RD_WRAP_EN: addresses wrap past L-1 instead of truncating the burst.
module vreg_burst_reader #(
  parameter int unsigned W = 32,
  parameter int unsigned L = 32,
  parameter int unsigned A = 5
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [A-1:0] cmd_addr,
  input  logic [A:0]   cmd_len,
  output logic [A-1:0] rf_addr,
  output logic         rf_write,
  input  logic [W-1:0] rf_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam logic [A:0]   LenMax  = (A+1)'(L);
  localparam logic [A-1:0] AddrMax = A'(L - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e       r_state;
  logic [A-1:0] r_addr;
  logic [A:0]   r_remain;
  logic [W-1:0] r_mem [2];
  logic         r_mem_last [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_busy;

  logic         w_push;
  logic         w_pop;
  logic         w_hs;
  logic         w_last_push;
  logic [1:0]   w_count_next;
  logic [A:0]   w_len_clamp;
  logic [A:0]   w_len_eff;
  logic [A-1:0] w_addr_next;
`ifndef VREG_RD_WRAP_EN
  logic [A:0]   w_room;
`endif

  assign rf_write  = 1'b0;
  assign cmd_ready = (r_state == StIdle) && (r_count == 2'd0);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];
  assign out_last  = out_valid && r_mem_last[r_rd_ptr];
  assign busy      = r_busy;
  assign rf_addr   = (r_state == StRead) ? r_addr : '0;

  assign w_hs         = cmd_valid && cmd_ready;
  assign w_pop        = out_valid && out_ready;
  assign w_push       = (r_state == StRead) && ((r_count != 2'd2) || w_pop);
  assign w_last_push  = (r_remain == (A+1)'(1));
  assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);
  assign w_len_clamp  = (cmd_len > LenMax) ? LenMax : cmd_len;
  assign w_addr_next  = (r_addr == AddrMax) ? '0 : r_addr + 1'b1;

  // Without wrap the burst is cut at the last entry, so that beat carries out_last.
  always_comb begin
`ifdef VREG_RD_WRAP_EN
    w_len_eff = w_len_clamp;
`else
    w_room    = LenMax - {1'b0, cmd_addr};
    w_len_eff = (w_len_clamp > w_room) ? w_room : w_len_clamp;
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_remain      <= '0;
      r_mem[0]      <= '0;
      r_mem[1]      <= '0;
      r_mem_last[0] <= 1'b0;
      r_mem_last[1] <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_busy        <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_mem[r_wr_ptr]      <= rf_rdata;
        r_mem_last[r_wr_ptr] <= w_last_push;
        r_wr_ptr             <= ~r_wr_ptr;
        r_addr               <= w_addr_next;
        r_remain             <= r_remain - 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        if (out_last) r_busy <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_hs && (w_len_eff != '0)) begin
            r_addr   <= cmd_addr;
            r_remain <= w_len_eff;
            r_busy   <= 1'b1;
            r_state  <= StRead;
          end
        end
        StRead: begin
          if (w_push && w_last_push) r_state <= StDrain;
        end
        StDrain: begin
          if (w_count_next == 2'd0) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/vreg_burst_reader.md
VREG_BURST_READER -- requirements
Module: vreg_burst_reader

Interface
REQ-001 SHALL have parameter W, default 32, register entry width in bits.
REQ-002 SHALL have parameter L, default 32, number of register entries.
REQ-003 SHALL have parameter A, default 5, entry address width, log2(L).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  burst command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when both high at a rising edge.
REQ-008 SHALL have port cmd_addr  input  A  first entry to read.
REQ-009 SHALL have port cmd_len  input  A+1  number of entries to read, 0..L.
REQ-010 SHALL have port rf_addr  output  A  address driven to one register-file port.
REQ-011 SHALL have port rf_write  output  1  port direction to register file, tied 0 (read).
REQ-012 SHALL have port rf_rdata  input  W  combinational read data for rf_addr.
REQ-013 SHALL have port out_valid  output  1  stream beat available.
REQ-014 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-015 SHALL have port out_data  output  W  beat data.
REQ-016 SHALL have port out_last  output  1  marks final beat of a burst.
REQ-017 SHALL have port busy  output  1  burst in progress.

Function
REQ-018 SHALL implement FSM IDLE, READ, DRAIN; IDLE->READ on command handshake with cmd_len>0; IDLE stays on cmd_len=0 (no beats); READ->DRAIN when the final entry is pushed; DRAIN->IDLE when buffer empties.
REQ-019 SHALL assert cmd_ready only in IDLE with an empty buffer.
REQ-020 SHALL latch cmd_addr and min(cmd_len, L) at handshake; cmd_len>L clamps to L.
REQ-021 SHALL in READ drive rf_addr with the current entry and push rf_rdata with last flag into a 2-entry FIFO at the same edge, when FIFO count<2 or a pop occurs that cycle.
REQ-022 SHALL advance address and decrement remaining count only on a push; no push -> rf_addr held.
REQ-023 SHALL give first out_valid in cycle 2 after the handshake edge (handshake at edge 0, push at edge 1).
REQ-024 SHALL sustain one beat per cycle while out_ready is held high.
REQ-025 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL assert busy from the cycle after handshake until the out_last beat is accepted.
REQ-027 SHALL drive rf_addr=0 in IDLE and DRAIN.

Reset
REQ-028 SHALL on n_reset low immediately: FSM IDLE, FIFO empty, out_valid=0, out_last=0, out_data=0, busy=0, rf_addr=0, cmd_ready=1 after release.
REQ-029 SHALL discard in-flight burst and buffered beats on reset mid-operation; no beat emitted after release without a new command.

Configuration
REQ-030 SHALL use macro VREG_RD_WRAP_EN; defined: address after L-1 wraps to 0 and all latched beats are issued (L must be 2**A).
REQ-031 SHALL without VREG_RD_WRAP_EN stop issue after entry L-1; that beat carries out_last and remaining count is dropped.

Verification
REQ-032 SHALL cover addr=4, len=3, out_ready=1: beats entries 4,5,6 in cycles 2,3,4, out_last on entry 6, busy low cycle 5.
REQ-033 SHALL cover addr=0, len=4, out_ready low cycles 2-5: FIFO fills at 2 beats, rf_addr holds 2, no beat lost or duplicated after release.
REQ-034 SHALL cover addr=30, len=4, L=32: with VREG_RD_WRAP_EN beats 30,31,0,1; without, beats 30,31 with out_last on 31.
REQ-035 SHALL cover len=0 then len=40: first yields no beats, cmd_ready back next cycle; second clamps to 32 beats.
REQ-036 SHALL cover n_reset pulse during 8-beat burst after 3 beats: out_valid=0 immediately, no further beats, next command addr=10 len=1 returns entry 10.
REQ-037 SHALL check rf_write=0 in every cycle of every scenario.
